ub_write_sched: RTL and testbench
=================================

# ub_write_sched

Single-port access scheduler for the 64-entry, 32-bit unified buffer. It takes accumulator result stores (2 words each from acc1/acc2), host activation loads, and activation read bursts for input setup. It serialises them onto one memory port, one word per cycle, and owns the result write pointer. It sits between the accumulators/host interface and the unified buffer storage array.

## Interface
- DEPTH, 64: buffer entries; power of two.
- ADDR_W, 6: log2(DEPTH).
- DATA_W, 32: word width.
- ACC_LIMIT, 30: result region is [0, ACC_LIMIT); even, ≤ DEPTH.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- acc1_req  in  1  acc1 has a 2-word result; held until acc1_ack.
- acc1_data0, acc1_data1  in  DATA_W  acc1 words; stable while acc1_req high.
- acc1_ack  out  1  one-cycle pulse, acc1 store complete.
- acc2_req, acc2_data0, acc2_data1, acc2_ack: same as acc1.
- host_wr_valid  in  1  host write request.
- host_wr_addr  in  ADDR_W  host write address.
- host_wr_data  in  DATA_W  host write data.
- host_wr_ready  out  1  combinational; host write accepted when valid && ready.
- rd_start  in  1  start read burst (sampled in IDLE only).
- rd_base  in  ADDR_W  first read address.
- rd_len  in  4  burst length 1..8; 0 or >8 ignored.
- mem_we  out  1  registered write strobe.
- mem_re  out  1  registered read strobe.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- rd_busy  out  1  high in READ state.
- rd_done  out  1  one-cycle pulse after the last read beat.
- wr_ptr  out  ADDR_W  next result write address.
- full  out  1  result region exhausted (only without wrap).

## Operation
- States: IDLE, ACC_W0, ACC_W1, HOST_W, READ.
- IDLE priority: valid rd_start > accumulator request > host write.
- Accumulator arbitration is round-robin via a last_grant flag. After reset, last_grant = acc2, so acc1 wins the first tie. A lone requester always wins.
- Grant latches the selected requester's data0/data1.
- ACC_W0: mem_we=1, addr=wr_ptr, wdata=data0.
- ACC_W1: mem_we=1, addr=wr_ptr+1, wdata=data1. Pulse the granted ack. Update wr_ptr += 2 at end of cycle. Go to IDLE.
- Accumulator requests are not granted while full=1. Req stays pending with no ack.
- host_wr_ready = (state==IDLE) && !valid rd_start && !acc_grantable. On accept, latch addr/data and go to HOST_W. HOST_W: mem_we=1 for 1 cycle, then IDLE.
- Host writes may target any address, including the result region; wr_ptr is unaffected.
- READ: rd_len beats, mem_re=1, addr = rd_base+i mod DEPTH. Address wraps past 63 → 0.
- rd_done pulses in the IDLE cycle following the last beat. rd_start is ignored outside IDLE.
- mem_we and mem_re are never high together.

## Timing
- Reset values: state IDLE, wr_ptr 0, full 0, all strobes/acks/rd_done/rd_busy 0, mem_addr 0, mem_wdata 0, last_grant=acc2.
- Accumulator store: req sampled in IDLE at cycle 0. Write beats in cycles 1 and 2, with ack in cycle 2. Back in IDLE at cycle 3.
- Requester drops req the cycle after ack; a req still high in cycle 3 is a new store.
- Host write: accept at cycle 0, mem_we in cycle 1, IDLE in cycle 2.
- Read burst of N beats: mem_re in cycles 1..N, rd_done in cycle N+1. A new request can be sampled in cycle N+1.
- Simultaneous acc1_req and acc2_req: served back-to-back in round-robin order, with 3 cycles per store.
- Reset asserted mid-operation: next cycle is fully at reset values. The in-flight transaction is dropped with no ack. Words already written stay in memory.

## Configuration
- UB_WRITE_SCHED_WRAP_EN defined: when wr_ptr+2 ≥ ACC_LIMIT, wr_ptr wraps to 0 after the store. full is tied 0.
- Undefined: wr_ptr saturates at ACC_LIMIT and full=1. Further accumulator requests stall until reset. Host and read traffic are unaffected.

## Test plan
- Reset, then acc1_req with data 5/6 → mem_we at addr 0 (5) and addr 1 (6) in cycles 1–2; acc1_ack in cycle 2; wr_ptr=2.
- acc1_req and acc2_req asserted together, held until ack → acc1 writes addr 0,1, then acc2 writes addr 2,3; acks 3 cycles apart; wr_ptr=4.
- rd_start with rd_base=62, rd_len=4 and host_wr_valid in the same cycle → mem_re at 62, 63, 0, 1; host_wr_ready=0 during the burst; rd_done after the burst; host write issued next.
- Host write addr 0x1E data 11 while wr_ptr=6 → mem_we addr 30 data 11; wr_ptr stays 6.
- 15 acc stores with ACC_LIMIT=30 → with WRAP_EN, wr_ptr returns to 0 and the 16th store writes addr 0,1. Without it, full=1 and the 16th req receives no ack.
- Reset pulsed in ACC_W0 → no ack, no ACC_W1 beat, wr_ptr and all outputs 0 the next cycle.

Source files
------------

// File: rtl/ub_write_sched.sv
// ub_write_sched: single-port access scheduler for the unified buffer.
// Serialises accumulator result stores (two words each), host writes and
// activation read bursts onto one memory port, one word per cycle, and owns
// the result write pointer.
// Optional feature: define UB_WRITE_SCHED_WRAP_EN to make the result write
// pointer wrap to 0 instead of saturating at ACC_LIMIT and raising full.
module ub_write_sched #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int ACC_LIMIT = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc1_req,
  input  logic [DATA_W-1:0] acc1_data0,
  input  logic [DATA_W-1:0] acc1_data1,
  output logic              acc1_ack,
  input  logic              acc2_req,
  input  logic [DATA_W-1:0] acc2_data0,
  input  logic [DATA_W-1:0] acc2_data1,
  output logic              acc2_ack,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [3:0]        rd_len,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full
);

  typedef enum logic [2:0] {S_IDLE, S_ACC_W0, S_ACC_W1, S_HOST_W, S_READ} state_t;

  // The pointer carries one spare bit so it can hold ACC_LIMIT == DEPTH.
  localparam logic [ADDR_W:0] PTR_STEP  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] PTR_LIMIT = (ADDR_W+1)'(ACC_LIMIT);

  state_t              r_state, w_next_state;
  logic [ADDR_W:0]     r_wr_ptr, w_wr_ptr_n;
  logic                r_full, w_full_n;
  logic                r_last_grant, w_last_grant_n;
  logic                r_grant, w_grant_n;
  logic [DATA_W-1:0]   r_data1, w_data1_n;
  logic [3:0]          r_rd_len, w_rd_len_n;
  logic [3:0]          r_rd_cnt, w_rd_cnt_n;
  logic                r_mem_we, w_mem_we_n;
  logic                r_mem_re, w_mem_re_n;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_n;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_n;
  logic                r_acc1_ack, w_acc1_ack_n;
  logic                r_acc2_ack, w_acc2_ack_n;
  logic                r_rd_done, w_rd_done_n;

  logic                w_rd_valid;
  logic                w_acc_grantable;
  logic                w_pick_acc2;
  logic                w_host_accept;
  logic [ADDR_W:0]     w_ptr_plus2;
  logic [ADDR_W-1:0]   w_rd_next_addr;

  // Request qualification, round-robin choice and host handshake.
  always_comb begin
    w_rd_valid      = rd_start && (rd_len != 4'd0) && (rd_len <= 4'd8);
    w_acc_grantable = (acc1_req || acc2_req) && !r_full;
    w_pick_acc2     = acc2_req && (!acc1_req || !r_last_grant);
    host_wr_ready   = (r_state == S_IDLE) && !w_rd_valid && !w_acc_grantable;
    w_host_accept   = host_wr_valid && host_wr_ready;
    w_ptr_plus2     = r_wr_ptr + PTR_STEP;
    w_rd_next_addr  = ADDR_W'((int'(r_mem_addr) + 1) % DEPTH);
  end

  // Next-state and next-output logic; every port value is registered.
  always_comb begin
    w_next_state   = r_state;
    w_wr_ptr_n     = r_wr_ptr;
    w_full_n       = r_full;
    w_last_grant_n = r_last_grant;
    w_grant_n      = r_grant;
    w_data1_n      = r_data1;
    w_rd_len_n     = r_rd_len;
    w_rd_cnt_n     = r_rd_cnt;
    w_mem_we_n     = 1'b0;
    w_mem_re_n     = 1'b0;
    w_mem_addr_n   = r_mem_addr;
    w_mem_wdata_n  = r_mem_wdata;
    w_acc1_ack_n   = 1'b0;
    w_acc2_ack_n   = 1'b0;
    w_rd_done_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_valid) begin
          w_next_state = S_READ;
          w_mem_re_n   = 1'b1;
          w_mem_addr_n = rd_base;
          w_rd_len_n   = rd_len;
          w_rd_cnt_n   = 4'd1;
        end else if (w_acc_grantable) begin
          w_next_state   = S_ACC_W0;
          w_mem_we_n     = 1'b1;
          w_mem_addr_n   = r_wr_ptr[ADDR_W-1:0];
          w_mem_wdata_n  = w_pick_acc2 ? acc2_data0 : acc1_data0;
          w_data1_n      = w_pick_acc2 ? acc2_data1 : acc1_data1;
          w_grant_n      = w_pick_acc2;
          w_last_grant_n = w_pick_acc2;
        end else if (w_host_accept) begin
          w_next_state  = S_HOST_W;
          w_mem_we_n    = 1'b1;
          w_mem_addr_n  = host_wr_addr;
          w_mem_wdata_n = host_wr_data;
        end
      end
      S_ACC_W0: begin
        w_next_state  = S_ACC_W1;
        w_mem_we_n    = 1'b1;
        w_mem_addr_n  = r_wr_ptr[ADDR_W-1:0] + ADDR_W'(1);
        w_mem_wdata_n = r_data1;
        w_acc1_ack_n  = !r_grant;
        w_acc2_ack_n  = r_grant;
      end
      S_ACC_W1: begin
        w_next_state = S_IDLE;
`ifdef UB_WRITE_SCHED_WRAP_EN
        w_wr_ptr_n = (w_ptr_plus2 >= PTR_LIMIT) ? '0 : w_ptr_plus2;
        w_full_n   = 1'b0;
`else
        w_wr_ptr_n = (w_ptr_plus2 >= PTR_LIMIT) ? PTR_LIMIT : w_ptr_plus2;
        w_full_n   = (w_ptr_plus2 >= PTR_LIMIT);
`endif
      end
      S_HOST_W: begin
        w_next_state = S_IDLE;
      end
      S_READ: begin
        if (r_rd_cnt == r_rd_len) begin
          w_next_state = S_IDLE;
          w_rd_done_n  = 1'b1;
        end else begin
          w_mem_re_n   = 1'b1;
          w_mem_addr_n = w_rd_next_addr;
          w_rd_cnt_n   = r_rd_cnt + 4'd1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_full       <= 1'b0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_data1      <= '0;
      r_rd_len     <= '0;
      r_rd_cnt     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_acc1_ack   <= 1'b0;
      r_acc2_ack   <= 1'b0;
      r_rd_done    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wr_ptr     <= w_wr_ptr_n;
      r_full       <= w_full_n;
      r_last_grant <= w_last_grant_n;
      r_grant      <= w_grant_n;
      r_data1      <= w_data1_n;
      r_rd_len     <= w_rd_len_n;
      r_rd_cnt     <= w_rd_cnt_n;
      r_mem_we     <= w_mem_we_n;
      r_mem_re     <= w_mem_re_n;
      r_mem_addr   <= w_mem_addr_n;
      r_mem_wdata  <= w_mem_wdata_n;
      r_acc1_ack   <= w_acc1_ack_n;
      r_acc2_ack   <= w_acc2_ack_n;
      r_rd_done    <= w_rd_done_n;
    end
  end

  assign acc1_ack  = r_acc1_ack;
  assign acc2_ack  = r_acc2_ack;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_busy   = (r_state == S_READ);
  assign rd_done   = r_rd_done;
  assign wr_ptr    = r_wr_ptr[ADDR_W-1:0];
  assign full      = r_full;

endmodule

// File: tb/tb_ub_write_sched.sv
// Self-checking bench for ub_write_sched. A monitor logs every memory beat,
// ack and rd_done with its cycle number; each scenario task compares that log
// against expectations computed from the scheduling rules.
module tb_ub_write_sched;
  localparam int DEPTH = 64, ADDR_W = 6, DATA_W = 32, ACC_LIMIT = 30;

  logic clk = 1'b0, reset = 1'b1;
  logic acc1_req = 1'b0, acc2_req = 1'b0, host_wr_valid = 1'b0, rd_start = 1'b0;
  logic [DATA_W-1:0] acc1_data0 = '0, acc1_data1 = '0, acc2_data0 = '0, acc2_data1 = '0, host_wr_data = '0;
  logic [ADDR_W-1:0] host_wr_addr = '0, rd_base = '0;
  logic [3:0] rd_len = '0;
  logic acc1_ack, acc2_ack, host_wr_ready, mem_we, mem_re, rd_busy, rd_done, full;
  logic [ADDR_W-1:0] mem_addr, wr_ptr;
  logic [DATA_W-1:0] mem_wdata;

  ub_write_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_LIMIT(ACC_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .acc1_req(acc1_req), .acc1_data0(acc1_data0), .acc1_data1(acc1_data1), .acc1_ack(acc1_ack),
    .acc2_req(acc2_req), .acc2_data0(acc2_data0), .acc2_data1(acc2_data1), .acc2_ack(acc2_ack),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_busy(rd_busy), .rd_done(rd_done), .wr_ptr(wr_ptr), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_t;
  typedef struct { int c; int who; } ack_t;
  typedef struct { logic [DATA_W-1:0] d0; logic [DATA_W-1:0] d1; } pair_t;

  beat_t wq[$], rq[$];
  ack_t  aq[$];
  int    dq[$];
  pair_t q1[$], q2[$];
  int    n1 = 0, n2 = 0;
  int    cyc = 0, collide = 0;
  int    checks = 0, failures = 0;

  // Cycle counter: value during a cycle is the number of the edge that began it.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor logging port activity in the middle of each cycle.
  always @(negedge clk) begin
    if (mem_we) wq.push_back('{c: cyc, a: mem_addr, d: mem_wdata});
    if (mem_re) rq.push_back('{c: cyc, a: mem_addr, d: '0});
    if (acc1_ack) aq.push_back('{c: cyc, who: 0});
    if (acc2_ack) aq.push_back('{c: cyc, who: 1});
    if (rd_done) dq.push_back(cyc);
    if (mem_we && mem_re) collide++;
  end

  function automatic int next_ptr(int p);
`ifdef UB_WRITE_SCHED_WRAP_EN
    return (p + 2 >= ACC_LIMIT) ? 0 : p + 2;
`else
    return (p + 2 >= ACC_LIMIT) ? ACC_LIMIT : p + 2;
`endif
  endfunction

  task automatic raise1();
    acc1_data0 = $urandom; acc1_data1 = $urandom; acc1_req = 1'b1;
    q1.push_back('{d0: acc1_data0, d1: acc1_data1});
  endtask

  task automatic raise2();
    acc2_data0 = $urandom; acc2_data1 = $urandom; acc2_req = 1'b1;
    q2.push_back('{d0: acc2_data0, d1: acc2_data1});
  endtask

  // Advance one cycle; requesters drop (or re-issue) their req the cycle after ack.
  task automatic tick();
    logic p1, p2;
    p1 = acc1_ack; p2 = acc2_ack;
    @(posedge clk); #1;
    if (p1) begin if (n1 > 0) begin n1--; raise1(); end else acc1_req = 1'b0; end
    if (p2) begin if (n2 > 0) begin n2--; raise2(); end else acc2_req = 1'b0; end
  endtask

  task automatic flush();
    wq.delete(); rq.delete(); aq.delete(); dq.delete();
  endtask

  task automatic do_reset();
    acc1_req = 0; acc2_req = 0; host_wr_valid = 0; rd_start = 0;
    n1 = 0; n2 = 0; q1.delete(); q2.delete();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    flush();
  endtask

  task automatic test_reset();
    do_reset();
    host_wr_valid = 1'b1; #1;
    checks++;
    if ({mem_we, mem_re, acc1_ack, acc2_ack, rd_busy, rd_done, full, host_wr_ready} !== 8'b0000_0001) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000001", {mem_we, mem_re, acc1_ack, acc2_ack, rd_busy, rd_done, full, host_wr_ready});
    end
    checks++; if (mem_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin failures++; $display("[TB] FAIL reset_wdata: got %0h expected 0", mem_wdata); end
    checks++; if (wr_ptr !== '0) begin failures++; $display("[TB] FAIL reset_ptr: got %0d expected 0", wr_ptr); end
    host_wr_valid = 1'b0;
  endtask

  task automatic test_single_store();
    int t0; pair_t p;
    raise1(); p = q1[0]; t0 = cyc;
    repeat (4) tick();
    q1.delete();
    checks++;
    if (wq.size() != 2) begin failures++; $display("[TB] FAIL store_beats: got %0d expected 2", wq.size()); end
    else begin
      checks++;
      if (wq[0].c != t0 + 1 || wq[0].a !== 6'd0 || wq[0].d !== p.d0) begin
        failures++; $display("[TB] FAIL store_w0: got c=%0d a=%0d d=%0h expected c=%0d a=0 d=%0h", wq[0].c - t0, wq[0].a, wq[0].d, 1, p.d0);
      end
      checks++;
      if (wq[1].c != t0 + 2 || wq[1].a !== 6'd1 || wq[1].d !== p.d1) begin
        failures++; $display("[TB] FAIL store_w1: got c=%0d a=%0d d=%0h expected c=%0d a=1 d=%0h", wq[1].c - t0, wq[1].a, wq[1].d, 2, p.d1);
      end
    end
    checks++;
    if (aq.size() != 1 || aq[0].c != t0 + 2 || aq[0].who != 0) begin
      failures++; $display("[TB] FAIL store_ack: got count=%0d expected one acc1 ack at cycle 2", aq.size());
    end
    checks++; if (wr_ptr !== 6'd2) begin failures++; $display("[TB] FAIL store_ptr: got %0d expected 2", wr_ptr); end
  endtask

  // Both accumulators request together; acc1 re-issues one more store.
  task automatic test_back_to_back();
    int t0; pair_t a0, a1, b0;
    int ec[6] = '{1, 2, 4, 5, 7, 8};
    int ac[3] = '{2, 5, 8};
    int aw[3] = '{0, 1, 0};
    logic [DATA_W-1:0] ed[6];
    do_reset(); flush();
    raise1(); raise2(); n1 = 1; t0 = cyc;
    repeat (10) tick();
    a0 = q1[0]; a1 = q1[1]; b0 = q2[0];
    ed = '{a0.d0, a0.d1, b0.d0, b0.d1, a1.d0, a1.d1};
    q1.delete(); q2.delete();
    checks++;
    if (wq.size() != 6) begin failures++; $display("[TB] FAIL bb_beats: got %0d expected 6", wq.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (wq[i].c != t0 + ec[i] || wq[i].a !== ADDR_W'(i) || wq[i].d !== ed[i]) begin
        failures++; $display("[TB] FAIL bb_beat%0d: got c=%0d a=%0d d=%0h expected c=%0d a=%0d d=%0h", i, wq[i].c - t0, wq[i].a, wq[i].d, ec[i], i, ed[i]);
      end
    end
    checks++;
    if (aq.size() != 3) begin failures++; $display("[TB] FAIL bb_acks: got %0d expected 3", aq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (aq[i].c != t0 + ac[i] || aq[i].who != aw[i]) begin
        failures++; $display("[TB] FAIL bb_ack%0d: got c=%0d who=%0d expected c=%0d who=%0d", i, aq[i].c - t0, aq[i].who, ac[i], aw[i]);
      end
    end
    checks++; if (wr_ptr !== 6'd6) begin failures++; $display("[TB] FAIL bb_ptr: got %0d expected 6", wr_ptr); end
  endtask

  task automatic test_host_write();
    int t0; logic [DATA_W-1:0] d;
    flush();
    d = $urandom; host_wr_addr = 6'h1E; host_wr_data = d; host_wr_valid = 1'b1; #1;
    checks++; if (host_wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL host_ready: got %b expected 1", host_wr_ready); end
    t0 = cyc; tick(); host_wr_valid = 1'b0; #1;
    checks++; if (host_wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL host_busy_ready: got %b expected 0", host_wr_ready); end
    tick(); tick();
    checks++;
    if (wq.size() != 1 || wq[0].c != t0 + 1 || wq[0].a !== 6'd30 || wq[0].d !== d) begin
      failures++; $display("[TB] FAIL host_beat: got count=%0d expected one write at addr 30 data %0h in cycle 1", wq.size(), d);
    end
    checks++; if (wr_ptr !== 6'd6) begin failures++; $display("[TB] FAIL host_ptr: got %0d expected 6", wr_ptr); end
    checks++; if (host_wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL host_idle_ready: got %b expected 1", host_wr_ready); end
  endtask

  task automatic test_read_burst();
    int t0; logic [ADDR_W-1:0] ha; logic [DATA_W-1:0] hd;
    flush();
    ha = ADDR_W'($urandom_range(0, DEPTH - 1)); hd = $urandom;
    rd_base = 6'd62; rd_len = 4'd4; rd_start = 1'b1;
    host_wr_addr = ha; host_wr_data = hd; host_wr_valid = 1'b1; #1;
    checks++; if (host_wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_start_ready: got %b expected 0", host_wr_ready); end
    t0 = cyc;
    for (int i = 1; i <= 4; i++) begin
      tick(); rd_start = 1'b0; #1;
      checks++;
      if (rd_busy !== 1'b1 || host_wr_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL rd_busy_beat%0d: got busy=%b ready=%b expected busy=1 ready=0", i, rd_busy, host_wr_ready);
      end
    end
    tick(); #1;
    checks++;
    if (rd_busy !== 1'b0 || host_wr_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rd_end: got busy=%b ready=%b expected busy=0 ready=1", rd_busy, host_wr_ready);
    end
    tick(); host_wr_valid = 1'b0; tick();
    checks++;
    if (rq.size() != 4) begin failures++; $display("[TB] FAIL rd_beats: got %0d expected 4", rq.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i].c != t0 + 1 + i || rq[i].a !== ADDR_W'((62 + i) % DEPTH)) begin
        failures++; $display("[TB] FAIL rd_beat%0d: got c=%0d a=%0d expected c=%0d a=%0d", i, rq[i].c - t0, rq[i].a, 1 + i, (62 + i) % DEPTH);
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] != t0 + 5) begin failures++; $display("[TB] FAIL rd_done: got count=%0d expected one pulse in cycle 5", dq.size()); end
    checks++;
    if (wq.size() != 1 || wq[0].c != t0 + 6 || wq[0].a !== ha || wq[0].d !== hd) begin
      failures++; $display("[TB] FAIL rd_host_after: got count=%0d expected one host write in cycle 6", wq.size());
    end
  endtask

  task automatic test_random_reads();
    int t0, base, len;
    int lens[6];
    lens = '{0, 8, 1, 9, $urandom_range(0, 15), $urandom_range(1, 8)};
    for (int k = 0; k < 6; k++) begin
      flush();
      base = $urandom_range(0, DEPTH - 1); len = lens[k];
      rd_base = ADDR_W'(base); rd_len = 4'(len); rd_start = 1'b1;
      t0 = cyc; tick(); rd_start = 1'b0;
      repeat (11) tick();
      if (len >= 1 && len <= 8) begin
        checks++;
        if (rq.size() != len) begin failures++; $display("[TB] FAIL rr%0d_beats: got %0d expected %0d", k, rq.size(), len); end
        else for (int i = 0; i < len; i++) begin
          checks++;
          if (rq[i].c != t0 + 1 + i || rq[i].a !== ADDR_W'((base + i) % DEPTH)) begin
            failures++; $display("[TB] FAIL rr%0d_beat%0d: got c=%0d a=%0d expected c=%0d a=%0d", k, i, rq[i].c - t0, rq[i].a, 1 + i, (base + i) % DEPTH);
          end
        end
        checks++;
        if (dq.size() != 1 || dq[0] != t0 + len + 1) begin failures++; $display("[TB] FAIL rr%0d_done: got count=%0d expected one pulse in cycle %0d", k, dq.size(), len + 1); end
      end else begin
        checks++;
        if (rq.size() != 0 || dq.size() != 0) begin
          failures++; $display("[TB] FAIL rr%0d_ignored: got beats=%0d done=%0d expected 0/0 for len %0d", k, rq.size(), dq.size(), len);
        end
      end
    end
  endtask

  task automatic test_fill();
    int k, budget, p, rem1, rem2, last, pick, t0, nack;
    pair_t e;
    do_reset();
    k = $urandom_range(1, 14);
    raise1(); raise2(); n1 = k - 1; n2 = 14 - k;
    budget = 200;
    while (aq.size() < 15 && budget > 0) begin tick(); budget--; end
    repeat (3) tick();
    checks++;
    if (aq.size() != 15) begin failures++; $display("[TB] FAIL fill_acks: got %0d expected 15 (cycle budget)", aq.size()); end
    p = 0; rem1 = k; rem2 = 15 - k; last = 1;
    nack = (aq.size() < 15) ? aq.size() : 15;
    for (int j = 0; j < nack; j++) begin
      pick = (rem1 > 0 && rem2 > 0) ? (last == 1 ? 0 : 1) : (rem1 > 0 ? 0 : 1);
      if (pick == 0) rem1--; else rem2--;
      last = pick;
      checks++;
      if (aq[j].who != pick) begin failures++; $display("[TB] FAIL fill_order%0d: got acc%0d expected acc%0d", j, aq[j].who + 1, pick + 1); end
      e = (aq[j].who == 0) ? q1.pop_front() : q2.pop_front();
      checks++;
      if (wq.size() < 2 * j + 2) begin failures++; $display("[TB] FAIL fill_beats%0d: got %0d expected %0d", j, wq.size(), 2 * j + 2); end
      else if (wq[2*j].a !== ADDR_W'(p) || wq[2*j].d !== e.d0 || wq[2*j].c != aq[j].c - 1 ||
               wq[2*j+1].a !== ADDR_W'(p + 1) || wq[2*j+1].d !== e.d1 || wq[2*j+1].c != aq[j].c) begin
        failures++; $display("[TB] FAIL fill_store%0d: got a=%0d,%0d expected a=%0d,%0d with data %0h,%0h", j, wq[2*j].a, wq[2*j+1].a, p, p + 1, e.d0, e.d1);
      end
      p = next_ptr(p);
    end
    checks++; if (wr_ptr !== ADDR_W'(p)) begin failures++; $display("[TB] FAIL fill_ptr: got %0d expected %0d", wr_ptr, p); end
`ifdef UB_WRITE_SCHED_WRAP_EN
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL fill_full: got %b expected 0", full); end
    flush(); q1.delete(); raise1(); e = q1[0]; t0 = cyc;
    repeat (6) tick();
    q1.delete();
    checks++;
    if (aq.size() != 1 || aq[0].c != t0 + 2 || wq.size() != 2) begin
      failures++; $display("[TB] FAIL wrap_store: got acks=%0d beats=%0d expected 1/2", aq.size(), wq.size());
    end else begin
      checks++;
      if (wq[0].a !== 6'd0 || wq[0].d !== e.d0 || wq[1].a !== 6'd1 || wq[1].d !== e.d1) begin
        failures++; $display("[TB] FAIL wrap_addr: got a=%0d,%0d expected a=0,1", wq[0].a, wq[1].a);
      end
    end
`else
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    flush(); q1.delete(); raise1();
    repeat (6) tick();
    checks++;
    if (aq.size() != 0 || wq.size() != 0) begin failures++; $display("[TB] FAIL full_stall: got acks=%0d beats=%0d expected 0/0", aq.size(), wq.size()); end
    host_wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); host_wr_data = $urandom; host_wr_valid = 1'b1; #1;
    checks++; if (host_wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_host_ready: got %b expected 1", host_wr_ready); end
    tick(); host_wr_valid = 1'b0; tick();
    checks++;
    if (wq.size() != 1 || wq[0].a !== host_wr_addr || wq[0].d !== host_wr_data) begin
      failures++; $display("[TB] FAIL full_host_write: got beats=%0d expected 1", wq.size());
    end
    acc1_req = 1'b0; q1.delete();
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    raise1(); tick();
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL mid_w0: got %b expected 1", mem_we); end
    reset = 1'b1; tick();
    checks++;
    if ({mem_we, mem_re, acc1_ack, acc2_ack, rd_busy, rd_done, full} !== 7'b0) begin
      failures++; $display("[TB] FAIL mid_flags: got %b expected 0000000", {mem_we, mem_re, acc1_ack, acc2_ack, rd_busy, rd_done, full});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || wr_ptr !== '0) begin
      failures++; $display("[TB] FAIL mid_values: got addr=%0d wdata=%0h ptr=%0d expected 0/0/0", mem_addr, mem_wdata, wr_ptr);
    end
    reset = 1'b0; acc1_req = 1'b0; q1.delete();
    repeat (4) tick();
    checks++;
    if (aq.size() != 0 || wq.size() != 1) begin failures++; $display("[TB] FAIL mid_dropped: got acks=%0d beats=%0d expected 0/1", aq.size(), wq.size()); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_host_write();
    test_read_burst();
    test_random_reads();
    test_fill();
    test_reset_mid();
    checks++;
    if (collide != 0) begin failures++; $display("[TB] FAIL we_re_overlap: got %0d cycles expected 0", collide); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
